cordic_seq_ctrl: RTL

//  Iterative CORDIC sequencer. Accepts one Q2.30 angle in radians and runs ITER

---
 rtl/cordic_seq_ctrl_if.sv | 23 ++
 rtl/cordic_seq_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl_if.sv
// Handshake and data bundle for cordic_seq_ctrl: angle in on the valid/ready input side,
// cos/sin/err out on the valid/ready output side, plus a busy status.
interface cordic_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] cos_out;
  logic [31:0] sin_out;
  logic        out_err;
  logic        busy;

  modport master (
    output in_valid, angle, out_ready,
    input  in_ready, out_valid, cos_out, sin_out, out_err, busy
  );

  modport slave (
    input  in_valid, angle, out_ready,
    output in_ready, out_valid, cos_out, sin_out, out_err, busy
  );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Iterative rotation-mode CORDIC: one Q2.30 angle in, ITER micro-rotations (one per clock), cos/sin out.
// Define CORDIC_GAIN_COMP_EN to preload x with K (true cos/sin); otherwise results carry the 1/K gain.
module cordic_seq_ctrl #(
  parameter int ITER = 16
) (
  input logic              clk,
  input logic              rst,
  cordic_seq_ctrl_if.slave bus
);

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [31:0] X0 = 32'h26DD3B6A;
`else
  localparam logic [31:0] X0 = 32'h40000000;
`endif
  localparam logic [32:0] HALF_PI = 33'h0_6487ED51;
  localparam logic [4:0]  I_LAST  = 5'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e      state_q;
  logic [31:0] x_q, y_q, z_q;
  logic [4:0]  i_q;
  logic        err_q;
  logic [31:0] cos_q, sin_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        busy_q;

  logic [31:0] x_d, y_d, z_d;
  logic [31:0] x_sh, y_sh, atan_i;
  logic [32:0] ang_mag;
  logic        ang_err;

  // round(atan(2^-i) * 2^30); past i=10 the value is just 2^(30-i)
  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_rom = 32'h3243F6A9;
      5'd1:  atan_rom = 32'h1DAC6705;
      5'd2:  atan_rom = 32'h0FADBAFD;
      5'd3:  atan_rom = 32'h07F56EA7;
      5'd4:  atan_rom = 32'h03FEAB77;
      5'd5:  atan_rom = 32'h01FFD55C;
      5'd6:  atan_rom = 32'h00FFFAAC;
      5'd7:  atan_rom = 32'h007FFF55;
      5'd8:  atan_rom = 32'h003FFFEB;
      5'd9:  atan_rom = 32'h001FFFFD;
      5'd10: atan_rom = 32'h00100000;
      5'd11: atan_rom = 32'h00080000;
      5'd12: atan_rom = 32'h00040000;
      5'd13: atan_rom = 32'h00020000;
      5'd14: atan_rom = 32'h00010000;
      5'd15: atan_rom = 32'h00008000;
      5'd16: atan_rom = 32'h00004000;
      5'd17: atan_rom = 32'h00002000;
      5'd18: atan_rom = 32'h00001000;
      5'd19: atan_rom = 32'h00000800;
      5'd20: atan_rom = 32'h00000400;
      5'd21: atan_rom = 32'h00000200;
      5'd22: atan_rom = 32'h00000100;
      5'd23: atan_rom = 32'h00000080;
      5'd24: atan_rom = 32'h00000040;
      5'd25: atan_rom = 32'h00000020;
      5'd26: atan_rom = 32'h00000010;
      5'd27: atan_rom = 32'h00000008;
      5'd28: atan_rom = 32'h00000004;
      5'd29: atan_rom = 32'h00000002;
      default: atan_rom = 32'h00000000;
    endcase
  endfunction

  always_comb begin
    x_sh   = $signed(x_q) >>> i_q;
    y_sh   = $signed(y_q) >>> i_q;
    atan_i = atan_rom(i_q);
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    // Negative residual angle rotates clockwise (d = -1)
    if (z_q[31]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_i;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_i;
    end
  end

  // 33-bit magnitude so that 0x80000000 does not wrap back to a small value
  assign ang_mag = bus.angle[31] ? (33'd0 - {1'b1, bus.angle}) : {1'b0, bus.angle};
  assign ang_err = (ang_mag > HALF_PI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      err_q       <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= X0;
            y_q        <= '0;
            z_q        <= bus.angle;
            i_q        <= '0;
            err_q      <= ang_err;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 5'd1;
          if (i_q == I_LAST) begin
            cos_q       <= err_q ? 32'h0 : x_d;
            sin_q       <= err_q ? 32'h0 : y_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;
  assign bus.out_err   = err_q;
  assign bus.busy      = busy_q;

endmodule
